// File: rtl/frame_buffer_fifo.sv
// AXI-Stream packet FIFO on a circular RAM: cut-through or store-and-forward
// release, with forced cut-through when a packet outgrows the buffer.
module frame_buffer_fifo #(
    parameter int DATA_WIDTH        = 64,
    parameter int DEPTH             = 64,
    parameter int STORE_AND_FORWARD = 0,
    parameter int ADDR_W            = $clog2(DEPTH)
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [DATA_WIDTH-1:0]   S_AXIS_tdata,
    input  logic [DATA_WIDTH/8-1:0] S_AXIS_tkeep,
    input  logic                    S_AXIS_tlast,
    input  logic                    S_AXIS_tvalid,
    output logic                    S_AXIS_tready,
    output logic [DATA_WIDTH-1:0]   M_AXIS_tdata,
    output logic [DATA_WIDTH/8-1:0] M_AXIS_tkeep,
    output logic                    M_AXIS_tlast,
    output logic                    M_AXIS_tvalid,
    input  logic                    M_AXIS_tready,
    output logic                    empty,
    output logic                    full,
    output logic [ADDR_W:0]         level,
    output logic [ADDR_W:0]         pkt_count,
    output logic                    oversize
);

    localparam int              KEEP_W   = DATA_WIDTH / 8;
    localparam int              ENTRY_W  = KEEP_W + 1 + DATA_WIDTH;
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);
    localparam logic            SAF      = (STORE_AND_FORWARD != 0);

    // Entry layout: {tkeep, tlast, tdata}
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] pkt_count_q, pkt_count_d;
    logic            s_tready_q, s_tready_d;
    logic            force_ct_q, force_ct_d;
    logic            oversize_q, oversize_d;

    logic [ADDR_W:0]    level_w;
    logic               empty_w, full_w;
    logic [ENTRY_W-1:0] head;
    logic               head_last;
    logic               force_set, force_ct, m_valid;
    logic               push, pop, push_last, pop_last;

    always_comb begin
        level_w   = wr_ptr_q - rd_ptr_q;
        empty_w   = (level_w == '0);
        full_w    = (level_w == FULL_LVL);
        head      = mem_q[rd_ptr_q[ADDR_W-1:0]];
        head_last = head[DATA_WIDTH];

        // A full buffer with no complete packet can never release in
        // store-and-forward mode, so fall back to cut-through immediately.
        force_set = SAF && full_w && (pkt_count_q == '0);
        force_ct  = force_ct_q || force_set;
        m_valid   = !empty_w && (!SAF || (pkt_count_q != '0) || force_ct);

        push      = S_AXIS_tvalid && s_tready_q;
        pop       = m_valid && M_AXIS_tready;
        push_last = push && S_AXIS_tlast;
        pop_last  = pop && head_last;

        wr_ptr_d    = wr_ptr_q + {{ADDR_W{1'b0}}, push};
        rd_ptr_d    = rd_ptr_q + {{ADDR_W{1'b0}}, pop};
        pkt_count_d = pkt_count_q + {{ADDR_W{1'b0}}, push_last}
                                  - {{ADDR_W{1'b0}}, pop_last};
        s_tready_d  = ((wr_ptr_d - rd_ptr_d) != FULL_LVL);

        force_ct_d = force_ct_q;
        if (pop_last)
            force_ct_d = 1'b0;
        else if (force_set)
            force_ct_d = 1'b1;
        oversize_d = oversize_q || force_set;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pkt_count_q <= '0;
            s_tready_q  <= 1'b0;
            force_ct_q  <= 1'b0;
            oversize_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_count_q <= pkt_count_d;
            s_tready_q  <= s_tready_d;
            force_ct_q  <= force_ct_d;
            oversize_q  <= oversize_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (push)
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= {S_AXIS_tkeep, S_AXIS_tlast, S_AXIS_tdata};
    end

    assign S_AXIS_tready = s_tready_q;
    assign M_AXIS_tdata  = head[DATA_WIDTH-1:0];
    assign M_AXIS_tlast  = head_last;
    assign M_AXIS_tkeep  = head[ENTRY_W-1:DATA_WIDTH+1];
    assign M_AXIS_tvalid = m_valid;
    assign empty         = empty_w;
    assign full          = full_w;
    assign level         = level_w;
    assign pkt_count     = pkt_count_q;
    assign oversize      = oversize_d;

endmodule

// File: tb/tb_frame_buffer_fifo.sv
// Bench for frame_buffer_fifo: a cut-through and a store-and-forward instance
// share one stimulus stream, each checked every cycle against a queue model.
module tb_frame_buffer_fifo;
    localparam int DW = 32, KW = 4, DEPTH = 8, AW = 3;

    typedef struct packed {
        logic [KW-1:0] keep;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic ACLK = 1'b0;
    logic ARESETN;
    always #5 ACLK = ~ACLK;

    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast, s_tvalid, m_tready;

    logic          s_tready_w [2];
    logic [DW-1:0] m_tdata_w  [2];
    logic [KW-1:0] m_tkeep_w  [2];
    logic          m_tlast_w  [2];
    logic          m_tvalid_w [2];
    logic          empty_w    [2];
    logic          full_w     [2];
    logic [AW:0]   level_w    [2];
    logic [AW:0]   pkt_w      [2];
    logic          ovs_w      [2];

    frame_buffer_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .STORE_AND_FORWARD(0)) dut_ct (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXIS_tdata(s_tdata), .S_AXIS_tkeep(s_tkeep), .S_AXIS_tlast(s_tlast),
        .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(s_tready_w[0]),
        .M_AXIS_tdata(m_tdata_w[0]), .M_AXIS_tkeep(m_tkeep_w[0]), .M_AXIS_tlast(m_tlast_w[0]),
        .M_AXIS_tvalid(m_tvalid_w[0]), .M_AXIS_tready(m_tready),
        .empty(empty_w[0]), .full(full_w[0]), .level(level_w[0]),
        .pkt_count(pkt_w[0]), .oversize(ovs_w[0])
    );

    frame_buffer_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .STORE_AND_FORWARD(1)) dut_sf (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXIS_tdata(s_tdata), .S_AXIS_tkeep(s_tkeep), .S_AXIS_tlast(s_tlast),
        .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(s_tready_w[1]),
        .M_AXIS_tdata(m_tdata_w[1]), .M_AXIS_tkeep(m_tkeep_w[1]), .M_AXIS_tlast(m_tlast_w[1]),
        .M_AXIS_tvalid(m_tvalid_w[1]), .M_AXIS_tready(m_tready),
        .empty(empty_w[1]), .full(full_w[1]), .level(level_w[1]),
        .pkt_count(pkt_w[1]), .oversize(ovs_w[1])
    );

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: per-instance beat queue plus oversize/fallback flags.
    beat_t mq[$];
    bit    mforce, movs, msready, msaf;
    beat_t q0[$], q1[$];
    bit    force_s [2], ovs_s [2], sready_s [2];

    task automatic load(input int i);
        if (i == 0) mq = q0; else mq = q1;
        mforce = force_s[i]; movs = ovs_s[i]; msready = sready_s[i]; msaf = (i == 1);
    endtask

    task automatic store(input int i);
        if (i == 0) q0 = mq; else q1 = mq;
        force_s[i] = mforce; ovs_s[i] = movs; sready_s[i] = msready;
    endtask

    function automatic int nlast();
        int n = 0;
        foreach (mq[k]) if (mq[k].last) n++;
        return n;
    endfunction

    function automatic bit exp_valid();
        return mq.size() > 0 && (!msaf || nlast() > 0 || mforce);
    endfunction

    task automatic model_reset();
        q0.delete(); q1.delete();
        for (int i = 0; i < 2; i++) begin
            force_s[i] = 0; ovs_s[i] = 0; sready_s[i] = 0;
        end
    endtask

    task automatic check_inst(input int i);
        bit v;
        load(i);
        v = exp_valid();
        chk($sformatf("s_tready[%0d]", i), s_tready_w[i], msready);
        chk($sformatf("m_tvalid[%0d]", i), m_tvalid_w[i], v);
        chk($sformatf("level[%0d]", i), level_w[i], 64'(mq.size()));
        chk($sformatf("empty[%0d]", i), empty_w[i], mq.size() == 0);
        chk($sformatf("full[%0d]", i), full_w[i], mq.size() == DEPTH);
        chk($sformatf("pkt_count[%0d]", i), pkt_w[i], 64'(nlast()));
        chk($sformatf("oversize[%0d]", i), ovs_w[i], movs);
        if (v) begin
            chk($sformatf("tdata[%0d]", i), m_tdata_w[i], mq[0].data);
            chk($sformatf("tkeep[%0d]", i), m_tkeep_w[i], mq[0].keep);
            chk($sformatf("tlast[%0d]", i), m_tlast_w[i], mq[0].last);
        end
    endtask

    task automatic update(input int i, input bit sv, input beat_t b, input bit mr);
        bit pu, po;
        beat_t h;
        load(i);
        pu = sv && msready;
        po = exp_valid() && mr;
        if (po) begin
            h = mq.pop_front();
            if (h.last) mforce = 0;
        end
        if (pu) mq.push_back(b);
        if (msaf && mq.size() == DEPTH && nlast() == 0) begin
            mforce = 1; movs = 1;
        end
        msready = (mq.size() != DEPTH);
        store(i);
    endtask

    // One clock: drive at the falling edge, check, advance model at the rising edge.
    task automatic step(input bit sv, input logic [DW-1:0] data, input bit tl, input bit mr,
                        output bit acc);
        beat_t b;
        b.data = data; b.last = tl; b.keep = KW'($urandom);
        s_tvalid = sv; s_tdata = b.data; s_tkeep = b.keep; s_tlast = tl; m_tready = mr;
        #1;
        check_inst(0);
        check_inst(1);
        acc = sv && sready_s[1];
        @(posedge ACLK);
        update(0, sv, b, mr);
        update(1, sv, b, mr);
        @(negedge ACLK);
    endtask

    task automatic push_beat(input logic [DW-1:0] data, input bit tl, input bit mr);
        bit acc = 0;
        int tries = 0;
        while (!acc && tries < 20) begin
            step(1'b1, data, tl, mr, acc);
            tries++;
        end
        if (!acc) begin
            n_tests++; n_fail++;
            $display("FAIL push_timeout: beat %0h not accepted after %0d cycles", data, tries);
        end
    endtask

    task automatic idle(input int n, input bit mr);
        bit acc;
        repeat (n) step(1'b0, '0, 1'b0, mr, acc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        ARESETN = 1'b1; s_tvalid = 0; s_tdata = '0; s_tkeep = '0; s_tlast = 0; m_tready = 0;
        model_reset();
        #1 ARESETN = 1'b0;
        repeat (2) @(negedge ACLK);
        #1;
        check_inst(0);
        check_inst(1);
        @(negedge ACLK);
        ARESETN = 1'b1;

        // cut-through: three beats held, then drained in order
        push_beat(32'hA1, 0, 0);
        push_beat(32'hA2, 0, 0);
        push_beat(32'hA3, 1, 0);
        #1;
        chk("ct_level3", level_w[0], 3);
        chk("ct_pkt1", pkt_w[0], 1);
        chk("ct_head_valid", m_tvalid_w[0], 1);
        chk("ct_head_a1", m_tdata_w[0], 32'hA1);
        idle(3, 1);
        #1 chk("ct_empty", empty_w[0], 1);

        // store-and-forward: nothing released until tlast is in
        for (int k = 1; k <= 4; k++) begin
            push_beat(32'hB0 + k, k == 4, 0);
            #1 chk($sformatf("sf_tvalid_b%0d", k), m_tvalid_w[1], k == 4);
        end
        chk("sf_pkt1", pkt_w[1], 1);
        idle(5, 1);
        #1 chk("sf_pkt0", pkt_w[1], 0);

        // fill to full, refuse extra beat, pop one
        for (int k = 0; k < 8; k++) push_beat(32'hC0 + k, 0, 0);
        #1;
        chk("fill_full", full_w[0], 1);
        chk("fill_sready0", s_tready_w[0], 0);
        step(1, 32'hDEAD, 0, 0, acc);
        #1;
        chk("fill_level8", level_w[0], 8);
        chk("fill_head_c0", m_tdata_w[0], 32'hC0);
        chk("fill_sf_ovs", ovs_w[1], 1);
        chk("fill_sf_valid", m_tvalid_w[1], 1);
        step(0, '0, 0, 1, acc);
        #1;
        chk("pop_level7", level_w[0], 7);
        chk("pop_sready1", s_tready_w[0], 1);
        push_beat(32'hC8, 1, 0);
        idle(10, 1);

        // steady push/pop at level 4, pointers wrap several times
        for (int k = 0; k < 4; k++) push_beat(32'hD0 + k, 1, 0);
        for (int k = 0; k < 20; k++) step(1, 32'hE0 + k, 1, 1, acc);
        #1;
        chk("pp_level_ct", level_w[0], 4);
        chk("pp_level_sf", level_w[1], 4);
        idle(6, 1);

        // asynchronous reset mid-packet
        for (int k = 0; k < 5; k++) push_beat(32'hF0 + k, 0, 0);
        #1 chk("mid_level5", level_w[0], 5);
        #2 ARESETN = 1'b0;
        #1;
        chk("ar_sready", s_tready_w[0], 0);
        chk("ar_tvalid", m_tvalid_w[0], 0);
        chk("ar_empty", empty_w[0], 1);
        chk("ar_level", level_w[0], 0);
        chk("ar_pkt", pkt_w[0], 0);
        chk("ar_sf_ovs", ovs_w[1], 0);
        model_reset();
        @(negedge ACLK);
        ARESETN = 1'b1;
        step(0, '0, 0, 0, acc);
        #1 chk("ar_sready_rise", s_tready_w[0], 1);
        idle(4, 1);

        // oversize packet in store-and-forward
        for (int k = 0; k < 8; k++) push_beat(32'h100 + k, 0, 0);
        #1;
        chk("ovs_full", full_w[1], 1);
        chk("ovs_pkt0", pkt_w[1], 0);
        chk("ovs_flag", ovs_w[1], 1);
        chk("ovs_valid", m_tvalid_w[1], 1);
        for (int k = 8; k < 12; k++) push_beat(32'h100 + k, k == 11, 1);
        idle(12, 1);
        #1;
        chk("ovs_drained", empty_w[1], 1);
        chk("ovs_sticky", ovs_w[1], 1);
        push_beat(32'h200, 0, 0);
        push_beat(32'h201, 0, 0);
        #1 chk("ovs_force_cleared", m_tvalid_w[1], 0);
        push_beat(32'h202, 1, 0);
        idle(4, 1);

        // randomized traffic
        for (int k = 0; k < 800; k++)
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
                 (k % 200 < 100) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0), acc);
        push_beat(32'h300, 1, 1);
        idle(20, 1);
        #1;
        chk("end_empty_ct", empty_w[0], 1);
        chk("end_empty_sf", empty_w[1], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_buffer_fifo.md
# frame_buffer_fifo

Parametrised AXI-Stream packet buffer that sits between the upstream MAC/DMA stream and the frame former, replacing the shift-register buffer with a circular RAM FIFO. It stores tdata, tkeep and tlast per beat, and presents a standard AXIS manager port with tvalid/tready to the framer. It offers cut-through or store-and-forward release, with a forced cut-through fallback for packets larger than the buffer. It reports fill level and complete-packet count for framer scheduling and debug.

## Interface
- DATA_WIDTH, 64: tdata width in bits; multiple of 8.
- DEPTH, 64: entries; power of two, ≥4.
- STORE_AND_FORWARD, 0: 0 = cut-through, 1 = release only complete packets (with oversize fallback).
- ADDR_W, $clog2(DEPTH): derived; do not override.

- ACLK  in  1  single clock; all logic on rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- S_AXIS_tdata  in  DATA_WIDTH  input beat data.
- S_AXIS_tkeep  in  DATA_WIDTH/8  byte enables, stored unmodified.
- S_AXIS_tlast  in  1  end of packet.
- S_AXIS_tvalid  in  1  beat valid.
- S_AXIS_tready  out  1  registered; high when a push can be accepted.
- M_AXIS_tdata  out  DATA_WIDTH  head-of-FIFO data.
- M_AXIS_tkeep  out  DATA_WIDTH/8  head-of-FIFO keep.
- M_AXIS_tlast  out  1  head-of-FIFO last.
- M_AXIS_tvalid  out  1  head beat is releasable.
- M_AXIS_tready  in  1  framer accepts beat.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- level  out  ADDR_W+1  beats stored.
- pkt_count  out  ADDR_W+1  complete packets (tlast beats) stored.
- oversize  out  1  sticky; set when forced cut-through engaged.

## Operation
- Storage: DEPTH-entry array of {tkeep, tlast, tdata}; wr_ptr and rd_ptr are ADDR_W+1 bits, wrap naturally; index = low ADDR_W bits; level = wr_ptr − rd_ptr (modulo 2^(ADDR_W+1)).
- Push = S_AXIS_tvalid & S_AXIS_tready: write entry at wr_ptr, wr_ptr += 1.
- Pop = M_AXIS_tvalid & M_AXIS_tready: rd_ptr += 1.
- Simultaneous push and pop: both occur; level unchanged; pkt_count adjusts by (push&tlast) − (pop&tlast).
- S_AXIS_tready register <= (next level != DEPTH). Deasserts the cycle after the push that fills; reasserts the cycle after the first pop from full.
- M_AXIS_* data fields driven from entry at rd_ptr (first-word fall-through); undefined content when M_AXIS_tvalid = 0 is not checked.
- Release rule: M_AXIS_tvalid = !empty & (STORE_AND_FORWARD == 0 | pkt_count != 0 | force_ct).
- force_ct (STORE_AND_FORWARD only): set when full & pkt_count == 0; cleared on pop of a tlast beat. Setting force_ct also sets oversize (sticky until reset).
- Beats are never dropped; tkeep is passed through, never checked.
- Once M_AXIS_tvalid is high it stays high with stable data until pop (guaranteed, since release conditions only become false on a pop).

## Timing
- Reset (ARESETN low, asynchronous): wr_ptr = rd_ptr = 0, pkt_count = 0, force_ct = 0, oversize = 0, S_AXIS_tready = 0, M_AXIS_tvalid = 0, empty = 1, full = 0, level = 0. Array contents are not reset.
- S_AXIS_tready rises on the first ACLK edge after ARESETN deasserts.
- Reset mid-packet discards all contents and partial packets; no beats are emitted afterward until new pushes.
- Cut-through latency: beat pushed at edge N is on M_AXIS with tvalid at cycle N+1 (after edge N), if it is at the head.
- Store-and-forward latency: first beat of a packet becomes valid the cycle after its tlast beat is pushed.
- level, empty, full, and pkt_count update on the same edge as the push or pop.
- Full throughput: one beat per cycle in and out continuously when neither side stalls.

## Test plan
- DEPTH=8, cut-through: push 3 beats (0xA1..0xA3, tlast on 3rd) with M_AXIS_tready=0 -> level=3, pkt_count=1, M_AXIS_tvalid=1, tdata=0xA1; then tready=1 -> 0xA1, 0xA2, 0xA3 in order, tlast on 0xA3, empty=1.
- DEPTH=8, fill: push 8 beats with no tlast and tready low -> full=1, S_AXIS_tready=0 the next cycle, tvalid held 1 with no extra write; pop 1 -> S_AXIS_tready=1 the next cycle, level=7.
- Simultaneous push/pop at level=4 for 20 cycles -> level stays 4, output sequence equals input sequence, pointers wrap past 8 with no corruption.
- STORE_AND_FORWARD=1: push 4 beats, tlast on the 4th -> M_AXIS_tvalid=0 through beat 3, and 1 the cycle after beat 4; pkt_count 0→1→0 after draining.
- STORE_AND_FORWARD=1, DEPTH=8: push 12-beat packet -> at full with pkt_count=0, oversize=1 and tvalid=1; all 12 beats drain in order; force_ct clears after tlast pop; oversize stays 1.
- Assert ARESETN low asynchronously mid-packet at level=5 -> all outputs take reset values immediately; S_AXIS_tready=1 on the first edge after release; no stale beats appear.
